cv32e40x_prefetch_queue: RTL and testbench

Parametrised word-fetch prefetcher with a configurable number of outstanding bus transactions and a configurable-depth instruction queue. It sits between the OBI instruction transaction interface and the alignment/decompression stage. It issues sequential word-aligned fetches and buffers responses with their addresses and error flags. On a branch it flushes the queue and silently discards the responses of transactions already in flight. After a bus error it stops fetching until the next branch.

---
 rtl/cv32e40x_prefetch_queue_if.sv | 35 +++
 rtl/cv32e40x_prefetch_queue.sv | 93 +++++++++
 tb/tb_cv32e40x_prefetch_queue.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cv32e40x_prefetch_queue_if.sv
// cv32e40x_prefetch_queue_if: fetch control, OBI transaction/response and queue output signals
interface cv32e40x_prefetch_queue_if #(
    parameter int MAX_OUTSTND = 2
);
    logic                               fetch_enable_i;
    logic                               branch_i;
    logic [31:0]                        branch_addr_i;
    logic                               trans_valid_o;
    logic                               trans_ready_i;
    logic [31:0]                        trans_addr_o;
    logic                               resp_valid_i;
    logic [31:0]                        resp_rdata_i;
    logic                               resp_err_i;
    logic                               out_valid_o;
    logic                               out_ready_i;
    logic [31:0]                        out_rdata_o;
    logic [31:0]                        out_addr_o;
    logic                               out_err_o;
    logic [$clog2(MAX_OUTSTND+1)-1:0]   outstnd_cnt_o;
    logic                               busy_o;

    modport master (
        input  fetch_enable_i, branch_i, branch_addr_i, trans_ready_i,
               resp_valid_i, resp_rdata_i, resp_err_i, out_ready_i,
        output trans_valid_o, trans_addr_o, out_valid_o, out_rdata_o,
               out_addr_o, out_err_o, outstnd_cnt_o, busy_o
    );

    modport slave (
        output fetch_enable_i, branch_i, branch_addr_i, trans_ready_i,
               resp_valid_i, resp_rdata_i, resp_err_i, out_ready_i,
        input  trans_valid_o, trans_addr_o, out_valid_o, out_rdata_o,
               out_addr_o, out_err_o, outstnd_cnt_o, busy_o
    );
endinterface

// File: rtl/cv32e40x_prefetch_queue.sv
// cv32e40x_prefetch_queue: sequential word prefetcher with in-flight discard on branch and halt on bus error
module cv32e40x_prefetch_queue #(
    parameter int DEPTH       = 4,
    parameter int MAX_OUTSTND = 2
) (
    input logic                       clk,
    input logic                       rst,
    cv32e40x_prefetch_queue_if.master bus
);
    localparam int OW = $clog2(MAX_OUTSTND + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [CW-1:0] count;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic [OW-1:0] live;
    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [31:0]   fetch_addr;
    logic [31:0]   head_addr;
    logic [31:0]   branch_addr;
    logic          halted;
    logic          credit_ok;
    logic          hs;
    logic          drop;
    logic          push;
    logic          pop;
    logic [32:0]   mem [DEPTH];
    logic          unused_baddr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (32'(p) == DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign unused_baddr = ^bus.branch_addr_i[1:0];
    assign branch_addr  = {bus.branch_addr_i[31:2], 2'b00};
    assign live         = outstanding - discard;
    // A branch empties the queue and orphans every in-flight word, so all credit is free that cycle
    assign credit_ok    = bus.branch_i | ((32'(count) + 32'(live)) < DEPTH);
    assign bus.trans_valid_o = ~rst & bus.fetch_enable_i & (bus.branch_i | ~halted)
                             & (32'(outstanding) < MAX_OUTSTND) & credit_ok;
    assign bus.trans_addr_o  = bus.branch_i ? branch_addr : fetch_addr;
    assign hs   = bus.trans_valid_o & bus.trans_ready_i;
    assign drop = (discard != '0) | bus.branch_i;
    assign push = bus.resp_valid_i & ~drop;
    assign bus.out_valid_o   = (count != '0) & ~bus.branch_i;
    assign pop  = bus.out_valid_o & bus.out_ready_i;
    assign bus.out_rdata_o   = mem[rptr][31:0];
    assign bus.out_err_o     = bus.out_valid_o & mem[rptr][32];
    assign bus.out_addr_o    = head_addr;
    assign bus.outstnd_cnt_o = outstanding;
    assign bus.busy_o        = (outstanding != '0) | (count != '0);

    // Bus-side bookkeeping: in-flight count, orphaned responses still due, next fetch address, error halt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
            fetch_addr  <= '0;
            halted      <= 1'b0;
        end else begin
            outstanding <= outstanding + OW'(hs) - OW'(bus.resp_valid_i);
            discard     <= bus.branch_i ? outstanding - OW'(bus.resp_valid_i)
                                        : discard - OW'(bus.resp_valid_i && discard != '0);
            fetch_addr  <= hs ? bus.trans_addr_o + 32'd4 : bus.branch_i ? branch_addr : fetch_addr;
            halted      <= ~bus.branch_i & (halted | (push & bus.resp_err_i));
        end
    end

    // Queue occupancy, pointers and head address; a branch flushes ahead of any push or pop
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            rptr      <= '0;
            wptr      <= '0;
            head_addr <= '0;
        end else begin
            count     <= bus.branch_i ? '0 : count + CW'(push) - CW'(pop);
            rptr      <= bus.branch_i ? '0 : pop ? next_ptr(rptr) : rptr;
            wptr      <= bus.branch_i ? '0 : push ? next_ptr(wptr) : wptr;
            head_addr <= bus.branch_i ? branch_addr : pop ? head_addr + 32'd4 : head_addr;
        end
    end

    // Entry storage needs no reset: an entry is only presented once count covers it
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= {bus.resp_err_i, bus.resp_rdata_i};
    end

    // Credit accounting must never let a response land in a full queue
    assert property (@(posedge clk) disable iff (rst) push |-> (32'(count) < DEPTH));
endmodule

// File: tb/tb_cv32e40x_prefetch_queue.sv
// tb_cv32e40x_prefetch_queue: vector table, directed corner sequences and random traffic against a queue model
module tb_cv32e40x_prefetch_queue;
    localparam int DEPTH = 4;
    localparam int MO    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cv32e40x_prefetch_queue_if #(.MAX_OUTSTND(MO)) bus();
    cv32e40x_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTND(MO)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic [31:0] addr; bit drop; } txn_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic err; } ent_t;
    typedef struct {
        logic fe, tr, rv; logic [31:0] rd; logic ordy;
        logic etv; logic [31:0] etaddr; logic eov; logic [31:0] eoaddr, erd; logic [1:0] ecnt;
    } vec_t;

    txn_t        m_if[$];
    ent_t        m_oq[$];
    logic [31:0] m_fa;
    bit          m_halt;
    vec_t        vt[6];
    int          tests = 0;
    int          fails = 0;
    int          dut_issued = 0;
    logic        fe, br, tr, rv, re, ordy;
    logic [31:0] ba, rd, err_addr;
    bit          auto_resp, err_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive();
        bus.fetch_enable_i = fe;
        bus.branch_i       = br;
        bus.branch_addr_i  = ba;
        bus.trans_ready_i  = tr;
        bus.resp_valid_i   = rv;
        bus.resp_rdata_i   = rd;
        bus.resp_err_i     = re;
        bus.out_ready_i    = ordy;
    endtask

    // One clock: drive inputs, compare against the model, then advance the model by the spec rules
    task automatic step();
        int          live;
        logic        e_tv, e_ov, hs;
        logic [31:0] e_taddr, ba_al;
        txn_t        t;
        ent_t        e;
        @(negedge clk);
        if (auto_resp) begin
            rv = m_if.size() != 0;
            rd = rv ? (m_if[0].addr ^ 32'hA5A5_0000) : 32'h0;
            re = rv && err_en && (m_if[0].addr == err_addr);
        end
        if (m_if.size() == 0) rv = 1'b0;
        drive();
        #1;
        ba_al = {ba[31:2], 2'b00};
        live = 0;
        foreach (m_if[i]) if (!m_if[i].drop) live++;
        e_tv    = fe && (br || !m_halt) && (m_if.size() < MO) && (br || (m_oq.size() + live < DEPTH));
        e_taddr = br ? ba_al : m_fa;
        e_ov    = (m_oq.size() != 0) && !br;
        if (bus.trans_valid_o && bus.trans_ready_i) dut_issued++;
        chk("trans_valid", 32'(bus.trans_valid_o), 32'(e_tv));
        chk("trans_addr", bus.trans_addr_o, e_taddr);
        chk("out_valid", 32'(bus.out_valid_o), 32'(e_ov));
        chk("outstnd_cnt", 32'(bus.outstnd_cnt_o), 32'(m_if.size()));
        chk("busy", 32'(bus.busy_o), 32'(m_if.size() != 0 || m_oq.size() != 0));
        if (e_ov) begin
            chk("out_addr", bus.out_addr_o, m_oq[0].addr);
            chk("out_rdata", bus.out_rdata_o, m_oq[0].data);
            chk("out_err", 32'(bus.out_err_o), 32'(m_oq[0].err));
        end else begin
            chk("out_err_idle", 32'(bus.out_err_o), 32'd0);
        end
        hs = e_tv && tr;
        if (e_ov && ordy) e = m_oq.pop_front();
        if (rv) begin
            t = m_if.pop_front();
            if (!t.drop && !br) begin
                e.addr = t.addr; e.data = rd; e.err = re;
                m_oq.push_back(e);
                if (re) m_halt = 1'b1;
            end
        end
        if (br) begin
            m_oq.delete();
            foreach (m_if[i]) m_if[i].drop = 1'b1;
            m_halt = 1'b0;
        end
        if (hs) begin
            t.addr = e_taddr; t.drop = 1'b0;
            m_if.push_back(t);
            m_fa = e_taddr + 32'd4;
        end else if (br) begin
            m_fa = ba_al;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fe = 0; br = 0; ba = 0; tr = 0; rv = 0; rd = 0; re = 0; ordy = 0;
        auto_resp = 0; err_en = 0; err_addr = 32'h0;
        drive();
        m_if.delete();
        m_oq.delete();
        m_fa = 32'h0;
        m_halt = 1'b0;
        dut_issued = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 32'h0,        2'd0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 32'hA0A0_0000, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0, 32'h0,        2'd1};
        vt[2] = '{1'b1, 1'b1, 1'b1, 32'hA0A0_0001, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0, 32'hA0A0_0000, 2'd1};
        vt[3] = '{1'b1, 1'b1, 1'b1, 32'hA0A0_0002, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h0, 32'hA0A0_0000, 2'd1};
        vt[4] = '{1'b0, 1'b1, 1'b1, 32'hA0A0_0003, 1'b0, 1'b0, 32'h10, 1'b1, 32'h4, 32'hA0A0_0001, 2'd1};
        vt[5] = '{1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h10, 1'b1, 32'h4, 32'hA0A0_0001, 2'd0};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            fe = vt[i].fe; tr = vt[i].tr; rv = vt[i].rv; rd = vt[i].rd; ordy = vt[i].ordy;
            step();
            chk("vec_tv", 32'(bus.trans_valid_o), 32'(vt[i].etv));
            chk("vec_taddr", bus.trans_addr_o, vt[i].etaddr);
            chk("vec_ov", 32'(bus.out_valid_o), 32'(vt[i].eov));
            chk("vec_cnt", 32'(bus.outstnd_cnt_o), 32'(vt[i].ecnt));
            if (vt[i].eov) begin
                chk("vec_oaddr", bus.out_addr_o, vt[i].eoaddr);
                chk("vec_ordata", bus.out_rdata_o, vt[i].erd);
            end
        end

        do_reset();
        fe = 1; tr = 1; ordy = 0; auto_resp = 1;
        repeat (8) step();
        chk("full_issued", 32'(dut_issued), 32'd4);
        chk("full_stall", 32'(bus.trans_valid_o), 32'd0);
        ordy = 1;
        step();
        chk("full_pop_cycle_tv", 32'(bus.trans_valid_o), 32'd0);
        ordy = 0;
        step();
        chk("full_reissue_tv", 32'(bus.trans_valid_o), 32'd1);
        chk("full_reissue_addr", bus.trans_addr_o, 32'h10);

        do_reset();
        fe = 1; tr = 1;
        step();
        step();
        br = 1; ba = 32'h1002;
        step();
        chk("br_taddr", bus.trans_addr_o, 32'h1000);
        chk("br_tv_blocked", 32'(bus.trans_valid_o), 32'd0);
        br = 0; rv = 1; rd = 32'hDEAD_0000;
        step();
        chk("br_drop0_ov", 32'(bus.out_valid_o), 32'd0);
        rd = 32'hDEAD_0004;
        step();
        chk("br_issue_addr", bus.trans_addr_o, 32'h1000);
        rd = 32'hC0DE_1000;
        step();
        chk("br_next_addr", bus.trans_addr_o, 32'h1004);
        rv = 0;
        step();
        chk("br_first_oaddr", bus.out_addr_o, 32'h1000);
        chk("br_first_rdata", bus.out_rdata_o, 32'hC0DE_1000);

        do_reset();
        fe = 1; tr = 1; ordy = 0;
        step();
        rv = 1; rd = 32'h1111_0000;
        step();
        rd = 32'h1111_0004;
        step();
        rv = 0;
        step();
        br = 1; ba = 32'h200; rv = 1; rd = 32'h1111_0008; ordy = 1; tr = 0;
        step();
        chk("brresp_no_ov", 32'(bus.out_valid_o), 32'd0);
        br = 0; rd = 32'h1111_000C;
        step();
        chk("brresp_ov", 32'(bus.out_valid_o), 32'd0);
        chk("brresp_cnt", 32'(bus.outstnd_cnt_o), 32'd1);
        rv = 0; tr = 1;
        step();
        chk("brresp_idle", 32'(bus.busy_o), 32'd0);
        chk("brresp_resume", bus.trans_addr_o, 32'h200);

        do_reset();
        fe = 1; tr = 1; ordy = 0; auto_resp = 1; err_en = 1; err_addr = 32'h8;
        repeat (6) step();
        ordy = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_addr", bus.out_addr_o, 32'(4 * i));
            chk("drain_err", 32'(bus.out_err_o), 32'(i == 2));
        end
        chk("halt_issued", 32'(dut_issued), 32'd4);
        ordy = 0; err_en = 0;
        step();
        chk("halt_tv", 32'(bus.trans_valid_o), 32'd0);
        br = 1; ba = 32'h40;
        step();
        chk("halt_br_tv", 32'(bus.trans_valid_o), 32'd1);
        chk("halt_br_addr", bus.trans_addr_o, 32'h40);
        br = 0;
        step();
        chk("halt_resume_addr", bus.trans_addr_o, 32'h44);

        do_reset();
        fe = 1; tr = 1; br = 1; ba = 32'hFFFF_FFFE;
        step();
        chk("wrap_first", bus.trans_addr_o, 32'hFFFF_FFFC);
        br = 0;
        step();
        chk("wrap_addr", bus.trans_addr_o, 32'h0);
        step();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_tv", 32'(bus.trans_valid_o), 32'd0);
        chk("arst_taddr", bus.trans_addr_o, 32'd0);
        chk("arst_ov", 32'(bus.out_valid_o), 32'd0);
        chk("arst_oaddr", bus.out_addr_o, 32'd0);
        chk("arst_oerr", 32'(bus.out_err_o), 32'd0);
        chk("arst_cnt", 32'(bus.outstnd_cnt_o), 32'd0);
        chk("arst_busy", 32'(bus.busy_o), 32'd0);

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            fe   = $urandom_range(0, 99) < 85;
            br   = $urandom_range(0, 99) < 5;
            ba   = $urandom;
            tr   = $urandom_range(0, 99) < 70;
            ordy = $urandom_range(0, 99) < 60;
            rv   = (m_if.size() != 0) && ($urandom_range(0, 99) < 50);
            rd   = $urandom;
            re   = $urandom_range(0, 99) < 4;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
